// File: rtl/pio_cmd_pkg.sv
// Shared definitions for the PIO command sequencer: FSM states, the CLR opcode and status bit positions.
// No logic lives here, so there is no latency or backpressure behaviour.
package pio_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_t;

    localparam logic [2:0] OP_CLR = 3'd7;

    localparam int STS_ACK_TGL     = 7;
    localparam int STS_BUSY        = 6;
    localparam int STS_OVERRUN     = 5;
    localparam int STS_TIMEOUT     = 4;
    localparam int STS_LAST_OP_MSB = 2;

endpackage

// File: rtl/pio_cmd_watchdog.sv
// WAIT_DONE watchdog: counts run cycles, held at zero while cleared.
// Expire is combinational in the TIMEOUT_CYCLES-th run cycle; no backpressure.
module pio_cmd_watchdog #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expire
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= 16'd0;
        end else if (i_clr) begin
            r_cnt <= 16'd0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // r_cnt holds the number of run cycles already completed
    assign o_expire = i_run && (r_cnt == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/pio_cmd_sequencer.sv
// Turns toggle-framed PIO command bytes into a valid/ready command plus completion ack; macro PIO_CMD_TIMEOUT_EN adds a WAIT_DONE watchdog.
// cmd_valid rises one cycle after the toggle is sampled; status is registered; cmd_ready stalls ISSUE indefinitely, toggles while busy are dropped as overrun.
module pio_cmd_sequencer
    import pio_cmd_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pio_in,
    output logic       cmd_valid,
    output logic [2:0] cmd_op,
    output logic [3:0] cmd_arg,
    input  logic       cmd_ready,
    input  logic       cmd_done,
    output logic [7:0] status_out
);

    state_t     r_state, w_state_nxt;
    logic       r_prev_tgl, w_prev_tgl_nxt;
    logic       r_ack_tgl, w_ack_tgl_nxt;
    logic       r_overrun, w_overrun_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic [2:0] r_last_op, w_last_op_nxt;
    logic [2:0] r_cmd_op, w_cmd_op_nxt;
    logic [3:0] r_cmd_arg, w_cmd_arg_nxt;

    logic       w_new_cmd;
    logic       w_wd_expire;

    assign w_new_cmd = pio_in[7] ^ r_prev_tgl;

`ifdef PIO_CMD_TIMEOUT_EN
    pio_cmd_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (r_state != WAIT_DONE),
        .i_run    (r_state == WAIT_DONE),
        .o_expire (w_wd_expire)
    );
`else
    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_prev_tgl <= 1'b0;
            r_ack_tgl  <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
            r_last_op  <= 3'd0;
            r_cmd_op   <= 3'd0;
            r_cmd_arg  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_tgl <= w_prev_tgl_nxt;
            r_ack_tgl  <= w_ack_tgl_nxt;
            r_overrun  <= w_overrun_nxt;
            r_timeout  <= w_timeout_nxt;
            r_last_op  <= w_last_op_nxt;
            r_cmd_op   <= w_cmd_op_nxt;
            r_cmd_arg  <= w_cmd_arg_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prev_tgl_nxt = r_prev_tgl;
        w_ack_tgl_nxt  = r_ack_tgl;
        w_overrun_nxt  = r_overrun;
        w_timeout_nxt  = r_timeout;
        w_last_op_nxt  = r_last_op;
        w_cmd_op_nxt   = r_cmd_op;
        w_cmd_arg_nxt  = r_cmd_arg;

        case (r_state)
            IDLE: begin
                if (w_new_cmd) begin
                    w_prev_tgl_nxt = pio_in[7];
                    w_last_op_nxt  = pio_in[6:4];
                    if (pio_in[6:4] == OP_CLR) begin
                        w_state_nxt = ACK;
                    end else begin
                        w_cmd_op_nxt  = pio_in[6:4];
                        w_cmd_arg_nxt = pio_in[3:0];
                        w_state_nxt   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cmd_done) begin
                    w_state_nxt = ACK;
                end else if (w_wd_expire) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ACK;
                end
            end
            ACK: begin
                w_ack_tgl_nxt = ~r_ack_tgl;
                // last_op is only ever 7 for a CLR, since opcode 7 is never issued
                if (r_last_op == OP_CLR) begin
                    w_overrun_nxt = 1'b0;
                    w_timeout_nxt = 1'b0;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Late in the block so an overrun set overrides a CLR in ACK
        if ((r_state != IDLE) && w_new_cmd) begin
            w_prev_tgl_nxt = pio_in[7];
            w_overrun_nxt  = 1'b1;
        end
    end

    assign cmd_valid = (r_state == ISSUE);
    assign cmd_op    = r_cmd_op;
    assign cmd_arg   = r_cmd_arg;

    always_comb begin
        status_out                                   = 8'h00;
        status_out[STS_ACK_TGL]                      = r_ack_tgl;
        status_out[STS_BUSY]                         = (r_state != IDLE);
        status_out[STS_OVERRUN]                      = r_overrun;
        status_out[STS_TIMEOUT]                      = r_timeout;
        status_out[STS_LAST_OP_MSB -: 3]             = r_last_op;
    end

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Bench for pio_cmd_sequencer: directed scenarios with literal expectations, then random traffic
// checked every cycle against a job-level model of the command protocol.
module tb_pio_cmd_sequencer;

    localparam logic [15:0] TMO = 16'd20;
`ifdef PIO_CMD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] pio_in;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       cmd_ready;
    logic       cmd_done;
    logic [7:0] status_out;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    pio_cmd_sequencer #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pio_in     (pio_in),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cmd_ready  (cmd_ready),
        .cmd_done   (cmd_done),
        .status_out (status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: one job in flight at a time, with offered/accepted/finished milestones
    bit       m_prev, m_ack, m_ovr, m_tmo;
    bit [2:0] m_last, m_op;
    bit [3:0] m_arg;
    bit       j_act, j_acc, j_fin, j_clr;
    int       j_wait;

    always @(posedge clk) begin
        bit n_new;
        if (!reset_n) begin
            m_prev = 0; m_ack = 0; m_ovr = 0; m_tmo = 0;
            m_last = 0; m_op = 0; m_arg = 0;
            j_act = 0; j_acc = 0; j_fin = 0; j_clr = 0; j_wait = 0;
        end else begin
            n_new = (pio_in[7] != m_prev);
            if (!j_act) begin
                if (n_new) begin
                    m_prev = pio_in[7];
                    m_last = pio_in[6:4];
                    j_act  = 1;
                    if (pio_in[6:4] == 3'd7) begin
                        j_clr = 1; j_acc = 1; j_fin = 1;
                    end else begin
                        j_clr = 0; j_acc = 0; j_fin = 0;
                        m_op  = pio_in[6:4];
                        m_arg = pio_in[3:0];
                    end
                end
            end else begin
                if (j_fin) begin
                    m_ack = ~m_ack;
                    if (j_clr) begin
                        m_ovr = 0;
                        m_tmo = 0;
                    end
                    j_act = 0;
                end else if (!j_acc) begin
                    if (cmd_ready) begin
                        j_acc  = 1;
                        j_wait = 0;
                    end
                end else if (cmd_done) begin
                    j_fin = 1;
                end else begin
                    j_wait++;
                    if (TMO_EN && j_wait == int'(TMO)) begin
                        m_tmo = 1;
                        j_fin = 1;
                    end
                end
                if (n_new) begin
                    m_ovr  = 1;
                    m_prev = pio_in[7];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model", {16'h0, cmd_valid, cmd_op, cmd_arg, status_out},
                {16'h0, (j_act && !j_acc), m_op, m_arg, m_ack, j_act, m_ovr, m_tmo, 1'b0, m_last});
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        bit lazy;
        int r;
        reset_n   = 1'b0;
        pio_in    = 8'h00;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        repeat (3) tick;
        cmp_en  = 1'b1;
        reset_n = 1'b1;

        // Idle after reset: nothing happens
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_status", status_out, 8'h00);
            chk("idle_valid", cmd_valid, 1'b0);
        end

        // Basic command with immediate ready
        pio_in = 8'h93; cmd_ready = 1'b1;
        tick;
        chk("basic_issue", {cmd_valid, cmd_op, cmd_arg, status_out[6]}, {1'b1, 3'd1, 4'd3, 1'b1});
        tick;
        chk("basic_accepted", {cmd_valid, status_out[6]}, 2'b01);
        cmd_ready = 1'b0;
        repeat (4) tick;
        cmd_done = 1'b1;
        tick;
        cmd_done = 1'b0;
        chk("basic_ack", status_out, 8'h41);
        tick;
        chk("basic_done", status_out, 8'h81);

        // Stalled ready with a stray done during ISSUE
        pio_in = 8'h25; cmd_ready = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("issue_hold", {cmd_valid, cmd_op, cmd_arg}, {1'b1, 3'd2, 4'd5});
            cmd_done = (i == 1);
            tick;
        end
        cmd_ready = 1'b1;
        tick;
        chk("stall_accept", cmd_valid, 1'b0);
        cmd_ready = 1'b0;
        tick; tick;
        chk("stray_done_ignored", status_out[6], 1'b1);
        cmd_done = 1'b1;
        tick;
        cmd_done = 1'b0;
        chk("stall_ack", status_out, 8'hC2);
        tick;
        chk("stall_done", status_out, 8'h02);

        // Overrun while waiting, then CLR
        pio_in = 8'h91; cmd_ready = 1'b1;
        tick; tick;
        cmd_ready = 1'b0;
        pio_in = 8'h1F;
        tick;
        chk("overrun_set", status_out, 8'h61);
        for (int i = 0; i < 3; i++) begin
            chk("overrun_no_issue", cmd_valid, 1'b0);
            tick;
        end
        cmd_done = 1'b1;
        tick;
        cmd_done = 1'b0;
        tick;
        chk("overrun_done", status_out, 8'hA1);
        tick;
        chk("overrun_single_ack", {cmd_valid, status_out}, {1'b0, 8'hA1});
        pio_in = 8'hF0;
        tick;
        chk("clr_ack", {cmd_valid, status_out}, {1'b0, 8'hE7});
        tick;
        chk("clr_done", status_out, 8'h07);

        // Toggle during CLR's ACK: overrun wins over the clear
        pio_in = 8'h70;
        tick;
        chk("clr2_ack", status_out, 8'h47);
        pio_in = 8'hF5;
        tick;
        chk("clr_vs_overrun", status_out, 8'hA7);
        pio_in = 8'h70;
        tick; tick;
        chk("clr3_done", status_out, 8'h07);

        // Core never completes
        pio_in = 8'hC4; cmd_ready = 1'b1;
        tick; tick;
        cmd_ready = 1'b0;
`ifdef PIO_CMD_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            chk("wait_before_tmo", {status_out[6], status_out[4]}, 2'b10);
            tick;
        end
        chk("tmo_ack", status_out, 8'h54);
        tick;
        chk("tmo_done", status_out, 8'h94);
`else
        for (int i = 0; i < 30; i++) begin
            chk("wait_forever", {status_out[6], status_out[4]}, 2'b10);
            tick;
        end
        cmd_done = 1'b1;
        tick;
        cmd_done = 1'b0;
        tick;
        chk("late_done", status_out, 8'h84);
`endif
        pio_in = 8'h70;
        tick; tick;
        chk("clr4_done", status_out, 8'h07);

        // Reset while waiting abandons the command
        pio_in = 8'hA9; cmd_ready = 1'b1;
        tick;
        chk("rst_issue", {cmd_valid, cmd_op, cmd_arg}, {1'b1, 3'd2, 4'd9});
        tick;
        cmd_ready = 1'b0;
        tick;
        reset_n = 1'b0;
        pio_in  = 8'h00;
        tick;
        chk("rst_mid", {cmd_valid, status_out}, {1'b0, 8'h00});
        reset_n  = 1'b1;
        cmd_done = 1'b1;
        tick;
        cmd_done = 1'b0;
        tick;
        chk("rst_done_ignored", {cmd_valid, status_out}, {1'b0, 8'h00});

        // Random traffic against the model
        lazy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) lazy = ($urandom % 2) == 1;
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom % 150 == 0) reset_n = 1'b0;
            r = int'($urandom % 16);
            if (r < 2) pio_in = {~pio_in[7], 3'($urandom), 4'($urandom)};
            else if (r < 5) pio_in[6:0] = 7'($urandom);
            cmd_ready = ($urandom % 3) != 0;
            cmd_done  = lazy ? (($urandom % 64) == 0) : (($urandom % 4) == 0);
            tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pio_cmd_sequencer.md
PIO_CMD_SEQUENCER -- requirements
Module: pio_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the WAIT_DONE watchdog limit in clk cycles (16-bit).
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port pio_in  input  8  command byte driven by the PIO output port: [7] new-command toggle, [6:4] opcode, [3:0] argument.
REQ-005 SHALL have port cmd_valid  output  1  command offered to the core.
REQ-006 SHALL have port cmd_op  output  3  latched opcode.
REQ-007 SHALL have port cmd_arg  output  4  latched argument.
REQ-008 SHALL have port cmd_ready  input  1  core accepts the command.
REQ-009 SHALL have port cmd_done  input  1  one-cycle core completion pulse.
REQ-010 SHALL have port status_out  output  8  status for the PIO input port: [7] ack_tgl, [6] busy, [5] overrun, [4] timeout, [3] 0, [2:0] last_op.

Function
REQ-011 SHALL keep prev_tgl, with reset value 0; a new command SHALL be detected when pio_in[7] != prev_tgl.
REQ-012 SHALL implement the FSM states IDLE, ISSUE, WAIT_DONE and ACK; reset state SHALL be IDLE.
REQ-013 In IDLE, on a detected command with opcode != 7, the FSM SHALL latch opcode/arg into cmd_op/cmd_arg/last_op, update prev_tgl, and enter ISSUE on the same edge; cmd_valid SHALL be high the cycle after the edge on which the toggle is sampled.
REQ-014 In ISSUE, cmd_valid SHALL be 1 and cmd_op/cmd_arg SHALL be stable until cmd_ready=1; on that edge the FSM SHALL go to WAIT_DONE, and cmd_valid SHALL be 0 the next cycle.
REQ-015 cmd_done SHALL be honoured only in WAIT_DONE; a cmd_done pulse in IDLE, ISSUE or ACK SHALL be ignored.
REQ-016 In WAIT_DONE, cmd_done=1 SHALL move the FSM to ACK.
REQ-017 ACK SHALL last exactly one cycle: ack_tgl flips, then the FSM returns to IDLE.
REQ-018 Opcode 7 (CLR) SHALL be handled internally: it is never offered on cmd_valid; it clears overrun and timeout, sets last_op=7, updates prev_tgl, and goes IDLE->ACK directly.
REQ-019 busy SHALL be 1 in ISSUE, WAIT_DONE and ACK, and 0 in IDLE.
REQ-020 A toggle change detected outside IDLE SHALL set overrun (sticky), update prev_tgl, and drop the command; ack_tgl SHALL not flip for the dropped command.
REQ-021 If a toggle change and a CLR completion coincide, the overrun set SHALL win.
REQ-022 pio_in[6:0] SHALL be ignored unless a toggle change is detected in IDLE.

Reset
REQ-023 While reset_n=0 at a clk edge, the block SHALL drive: state=IDLE, prev_tgl=0, ack_tgl=0, overrun=0, timeout=0, last_op=0, cmd_op=0, cmd_arg=0, cmd_valid=0, busy=0, and the watchdog counter=0.
REQ-024 Reset asserted mid-operation SHALL abandon the command, with cmd_valid=0 from the next cycle; there SHALL be no asynchronous path.
REQ-025 After reset, if pio_in[7]=1 already, one command SHALL be detected, which is intended: software re-synchronises by reading ack_tgl.

Configuration
REQ-026 With macro PIO_CMD_TIMEOUT_EN defined, a 16-bit counter SHALL run in WAIT_DONE, clearing on entry; when it reaches TIMEOUT_CYCLES without cmd_done, timeout SHALL be set (sticky) and the FSM SHALL go to ACK.
REQ-027 Without PIO_CMD_TIMEOUT_EN, there SHALL be no counter, WAIT_DONE SHALL wait indefinitely, and status_out[4] SHALL be constant 0.

Structure
REQ-028 The FSM state encoding, the opcode constant CLR=3'd7 and the status bit index constants SHALL reside in the shared package pio_cmd_pkg.
REQ-029 The watchdog SHALL be the single sub-module pio_cmd_watchdog (start/clear, expire output), instantiated only under PIO_CMD_TIMEOUT_EN.

Verification
REQ-030 Reset, pio_in=8'h00 -> status_out=8'h00, cmd_valid=0, and no command for 10 cycles.
REQ-031 pio_in=8'h93 (tgl=1, op=1, arg=3), cmd_ready=1 at once, cmd_done 5 cycles later -> cmd_valid high 1 cycle with op=1/arg=3, busy high, then status_out=8'h81.
REQ-032 cmd_ready held 0 for 4 cycles -> cmd_valid and op/arg stable all 4 cycles; a cmd_done pulse during ISSUE is ignored.
REQ-033 Toggle flipped again while in WAIT_DONE -> status_out[5]=1, no second cmd_valid, and ack_tgl flips once only; then pio_in op=7 with toggle flipped -> overrun=0, ack_tgl flips, and cmd_valid stays 0.
REQ-034 With PIO_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=20, no cmd_done -> timeout=1 after 20 cycles in WAIT_DONE, FSM passes through ACK, busy=0.
REQ-035 Reset asserted in WAIT_DONE -> next cycle status_out=8'h00, cmd_valid=0, and a later cmd_done is ignored.
